// File: rtl/j1_boot_loader_if.sv
// j1_boot_loader_if: byte stream in, instruction RAM write port
// and core control out, grouped for the boot loader.
interface j1_boot_loader_if #(
    parameter int ADDR_WIDTH = 13
) ();
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  prog_write_enable;
    logic [ADDR_WIDTH-1:0] prog_address;
    logic [15:0]           prog_data;
    logic                  core_active_low_reset;
    logic                  boot_done;
    logic                  boot_error;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  prog_write_enable,
        input  prog_address,
        input  prog_data,
        input  core_active_low_reset,
        input  boot_done,
        input  boot_error
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output prog_write_enable,
        output prog_address,
        output prog_data,
        output core_active_low_reset,
        output boot_done,
        output boot_error
    );
endinterface

// File: rtl/j1_boot_loader.sv
// j1_boot_loader: decodes a checksummed byte frame into 16-bit words,
// writes them to instruction RAM and releases the j1 core on success.
module j1_boot_loader #(
    parameter int          ADDR_WIDTH     = 13,
    parameter int          MAX_WORDS      = 8192,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input logic            clock,
    input logic            reset,
    j1_boot_loader_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CNT_LO  = 3'd1;
    localparam logic [2:0] S_CNT_HI  = 3'd2;
    localparam logic [2:0] S_DATA_LO = 3'd3;
    localparam logic [2:0] S_DATA_HI = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;
    localparam logic [2:0] S_RUN     = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [2:0]            state_q, state_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            lo_q, lo_d;
    logic [7:0]            cnt_lo_q, cnt_lo_d;
    logic [15:0]           n_q, n_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  ready_q;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           data_q, data_d;
    logic                  run_q, run_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  is_sync;
    logic                  last_word;
    logic                  in_frame;
    logic [15:0]           n_rx;

    assign accept    = bus.rx_valid & ready_q;
    assign is_sync   = (bus.rx_data == SYNC_BYTE);
    assign last_word = (32'(idx_q) + 32'd1 == 32'(n_q));
    assign n_rx      = {bus.rx_data, cnt_lo_q};
    assign in_frame  = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                       (state_q == S_DATA_LO) || (state_q == S_DATA_HI) ||
                       (state_q == S_CHECK);

    assign bus.rx_ready              = ready_q;
    assign bus.prog_write_enable     = we_q;
    assign bus.prog_address          = addr_q;
    assign bus.prog_data             = data_q;
    assign bus.core_active_low_reset = run_q;
    assign bus.boot_done             = run_q;
    assign bus.boot_error            = err_q;

    // Frame decoder, RAM write generation and inter-byte timeout
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        lo_d     = lo_q;
        cnt_lo_d = cnt_lo_q;
        n_d      = n_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        run_d    = run_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (accept && is_sync) begin
                    state_d = S_CNT_LO;
                    sum_d   = 8'h00;
                    err_d   = 1'b0;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    cnt_lo_d = bus.rx_data;
                    state_d  = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    n_d   = n_rx;
                    idx_d = '0;
                    if (n_rx == 16'd0 || 32'(n_rx) > 32'(MAX_WORDS)) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    lo_d    = bus.rx_data;
                    sum_d   = sum_q + bus.rx_data;
                    state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    sum_d   = sum_q + bus.rx_data;
                    we_d    = 1'b1;
                    addr_d  = idx_q[ADDR_WIDTH-1:0];
                    data_d  = {bus.rx_data, lo_q};
                    idx_d   = idx_q + 1'b1;
                    state_d = last_word ? S_CHECK : S_DATA_LO;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (bus.rx_data == sum_q) begin
                        state_d = S_RUN;
                        run_d   = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An accepted byte always beats the timeout on the same cycle.
        if (!in_frame || accept) begin
            tmo_d = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
            if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                state_d = S_ERROR;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sum_q    <= '0;
            lo_q     <= '0;
            cnt_lo_q <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            run_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            lo_q     <= lo_d;
            cnt_lo_q <= cnt_lo_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            ready_q  <= 1'b1;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            run_q    <= run_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_j1_boot_loader.sv
// tb_j1_boot_loader: directed frames with a write scoreboard for
// the instruction RAM port of the j1 boot loader.
module tb_j1_boot_loader;
    logic clock;
    logic reset;
    int   checks;
    int   failures;
    logic [28:0] sb[$];

    j1_boot_loader_if #(.ADDR_WIDTH(13)) bus ();

    j1_boot_loader #(
        .ADDR_WIDTH(13),
        .MAX_WORDS(8192),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        chk("rx_ready", 32'(bus.rx_ready), 32'd1);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clock);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic push(input logic [12:0] a, input logic [15:0] d);
        sb.push_back({a, d});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
        chk({tag, "_we"}, 32'(bus.prog_write_enable), 32'd0);
        chk({tag, "_addr"}, 32'(bus.prog_address), 32'd0);
        chk({tag, "_data"}, 32'(bus.prog_data), 32'd0);
        chk({tag, "_core"}, 32'(bus.core_active_low_reset), 32'd0);
        chk({tag, "_done"}, 32'(bus.boot_done), 32'd0);
        chk({tag, "_err"}, 32'(bus.boot_error), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1 check_reset_outputs("rst");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic good_frame();
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h34); push(13'd0, 16'h1234); send(8'h12);
        send(8'h78); push(13'd1, 16'h5678); send(8'h56);
        chk("pre_release", 32'(bus.core_active_low_reset), 32'd0);
        send(8'h14);
        chk("release_core", 32'(bus.core_active_low_reset), 32'd1);
        chk("release_done", 32'(bus.boot_done), 32'd1);
        chk("release_err", 32'(bus.boot_error), 32'd0);
    endtask

    // Scoreboard: every write strobe must match the oldest expected word
    always @(negedge clock) begin
        if (bus.prog_write_enable !== 1'b0 && !reset) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(bus.prog_address), 32'hFFFF_FFFF);
            end else begin
                logic [28:0] e;
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.prog_address), 32'(e[28:16]));
                chk("wr_data", 32'(bus.prog_data), 32'(e[15:0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s;
        logic [15:0] w;
        checks       = 0;
        failures     = 0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        reset        = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs("por");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 chk("ready_after_reset", 32'(bus.rx_ready), 32'd1);

        good_frame();
        chk("hold_addr", 32'(bus.prog_address), 32'd1);
        chk("hold_data", 32'(bus.prog_data), 32'h5678);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        chk("run_core", 32'(bus.core_active_low_reset), 32'd1);
        chk("run_err", 32'(bus.boot_error), 32'd0);
        do_reset();

        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h34); push(13'd0, 16'h1234); send(8'h12);
        send(8'h78); push(13'd1, 16'h5678); send(8'h56);
        send(8'h15);
        chk("badsum_core", 32'(bus.core_active_low_reset), 32'd0);
        chk("badsum_err", 32'(bus.boot_error), 32'd1);
        send(8'hA5);
        chk("err_clear_at_sync", 32'(bus.boot_error), 32'd0);
        send(8'h02); send(8'h00);
        send(8'h34); push(13'd0, 16'h1234); send(8'h12);
        send(8'h78); push(13'd1, 16'h5678); send(8'h56);
        send(8'h14);
        chk("retry_core", 32'(bus.core_active_low_reset), 32'd1);
        do_reset();

        send(8'h00); send(8'hFF); send(8'h5A);
        chk("garbage_err", 32'(bus.boot_error), 32'd0);
        good_frame();
        do_reset();

        send(8'hA5); send(8'h00); send(8'h00);
        chk("n0_err", 32'(bus.boot_error), 32'd1);
        send(8'hA5); send(8'h01); send(8'h20);
        chk("n8193_err", 32'(bus.boot_error), 32'd1);
        chk("n8193_core", 32'(bus.core_active_low_reset), 32'd0);
        do_reset();

        send(8'hA5); send(8'h02); send(8'h00); send(8'h34);
        repeat (15) @(posedge clock);
        #1 chk("gap15_err", 32'(bus.boot_error), 32'd0);
        @(posedge clock);
        #1 chk("gap16_err", 32'(bus.boot_error), 32'd1);
        send(8'h12); send(8'h78); send(8'h56); send(8'h14);
        chk("timeout_core", 32'(bus.core_active_low_reset), 32'd0);
        send(8'hA5); send(8'h02); send(8'h00); send(8'h34);
        repeat (15) @(posedge clock);
        push(13'd0, 16'h1234); send(8'h12);
        send(8'h78); push(13'd1, 16'h5678); send(8'h56);
        send(8'h14);
        chk("gap_ok_core", 32'(bus.core_active_low_reset), 32'd1);
        chk("gap_ok_err", 32'(bus.boot_error), 32'd0);
        do_reset();

        send(8'hA5); send(8'h02); send(8'h00); send(8'h34);
        do_reset();
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'hCD); push(13'd0, 16'hABCD); send(8'hAB);
        send(8'h78);
        chk("reload_core", 32'(bus.core_active_low_reset), 32'd1);
        do_reset();

        send(8'hA5); send(8'h00); send(8'h20);
        s = 8'h00;
        for (int i = 0; i < 8192; i++) begin
            w = {8'(i >> 8) ^ 8'h5A, 8'(i)};
            s = s + w[7:0] + w[15:8];
            send(w[7:0]);
            push(13'(i), w);
            send(w[15:8]);
        end
        chk("max_pre_check", 32'(bus.core_active_low_reset), 32'd0);
        send(s);
        chk("max_core", 32'(bus.core_active_low_reset), 32'd1);
        chk("max_last_addr", 32'(bus.prog_address), 32'd8191);

        repeat (3) @(posedge clock);
        #1 chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
